parity_mem_wr: RTL and testbench

PARITY_MEM_WR -- requirements
Module: parity_mem_wr

---
 rtl/parity_mem_wr.sv | 118 +++++++++++
 tb/tb_parity_mem_wr.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/parity_mem_wr.sv
// Small parity-protected write-once table: sequential fills up to DEPTH entries,
// registered reads with parity check, and a one-entry-per-cycle clear sweep.
module parity_mem_wr #(
   parameter  int DW    = 8,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_valid,
   input  logic [DW-1:0] wr_data,
   input  logic          wr_inv_par,
   output logic          wr_ready,
   input  logic          clear,
   input  logic [AW-1:0] rd_index,
   output logic [DW-1:0] rd_data,
   output logic          rd_parity,
   output logic          rd_err,
   output logic [AW:0]   count,
   output logic          full,
   output logic          busy
);

   typedef enum logic [1:0] {S_EMPTY, S_FILL, S_FULL, S_CLR} state_t;

   localparam logic [AW:0]   CNT_LAST = (AW+1)'(DEPTH - 1);
   localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

   state_t              state_q, state_d;
   logic [DW:0]         mem_q [DEPTH];
   logic [AW-1:0]       wr_ptr_q;
   logic [AW:0]         count_q;
   logic [AW-1:0]       clr_idx_q;
   logic [DW-1:0]       rd_data_q;
   logic                rd_parity_q;
   logic                rd_err_q;
   logic                wr_fire;

   function automatic logic par_even(input logic [DW-1:0] d);
      return ^d;
   endfunction

   assign wr_fire = wr_valid && wr_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_EMPTY;
      else     state_q <= state_d;
   end

   // Next-state logic; clear outranks a simultaneous write
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_EMPTY, S_FILL: begin
            if (clear) state_d = S_CLR;
            else if (wr_fire) state_d = (count_q == CNT_LAST) ? S_FULL : S_FILL;
         end
         S_FULL: begin
            if (clear) state_d = S_CLR;
         end
         S_CLR: begin
            if (clr_idx_q == IDX_LAST) state_d = S_EMPTY;
         end
         default: state_d = S_EMPTY;
      endcase
   end

   // Output decode
   always_comb begin
      wr_ready = 1'b0;
      full     = 1'b0;
      busy     = 1'b0;
      case (state_q)
         S_EMPTY, S_FILL: wr_ready = !clear;
         S_FULL:          full     = 1'b1;
         S_CLR:           busy     = 1'b1;
         default:         wr_ready = 1'b0;
      endcase
   end

   // Table, pointers and registered read port (read sees pre-write contents)
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         count_q     <= '0;
         clr_idx_q   <= '0;
         rd_data_q   <= '0;
         rd_parity_q <= 1'b0;
         rd_err_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rd_data_q   <= mem_q[rd_index][DW:1];
         rd_parity_q <= mem_q[rd_index][0];
         rd_err_q    <= par_even(mem_q[rd_index][DW:1]) != mem_q[rd_index][0];
         if (state_q == S_CLR) begin
            mem_q[clr_idx_q] <= '0;
            clr_idx_q        <= clr_idx_q + AW'(1);
            if (clr_idx_q == IDX_LAST) begin
               wr_ptr_q <= '0;
               count_q  <= '0;
            end
         end else if (clear) begin
            clr_idx_q <= '0;
         end else if (wr_fire) begin
            mem_q[wr_ptr_q] <= {wr_data, par_even(wr_data) ^ wr_inv_par};
            wr_ptr_q        <= wr_ptr_q + AW'(1);
            count_q         <= count_q + (AW+1)'(1);
         end
      end
   end

   assign rd_data   = rd_data_q;
   assign rd_parity = rd_parity_q;
   assign rd_err    = rd_err_q;
   assign count     = count_q;

endmodule

// File: tb/tb_parity_mem_wr.sv
// Bench for parity_mem_wr: a table-level model checked every cycle, plus
// directed scenarios with literal expected values.
module tb_parity_mem_wr;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_valid = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_inv_par = 1'b0;
   logic          clear = 1'b0;
   logic [AW-1:0] rd_index = '0;
   logic          wr_ready;
   logic [DW-1:0] rd_data;
   logic          rd_parity;
   logic          rd_err;
   logic [AW:0]   count;
   logic          full;
   logic          busy;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   parity_mem_wr #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_inv_par(wr_inv_par), .wr_ready(wr_ready), .clear(clear),
      .rd_index(rd_index), .rd_data(rd_data), .rd_parity(rd_parity),
      .rd_err(rd_err), .count(count), .full(full), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: table contents, fill count and remaining sweep cycles
   logic [DW:0]   m_mem [DEPTH];
   int            m_cnt = 0;
   int            m_sweep = 0;
   int            m_sidx = 0;
   logic [DW-1:0] e_data = '0;
   logic          e_par = 1'b0;
   logic          e_err = 1'b0;

   function automatic logic odd_ones(input logic [DW-1:0] d);
      return ($countones(d) % 2) == 1;
   endfunction

   // Compare at negedge, then advance the model with the inputs the next edge samples
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("m_rd_data",   32'(rd_data),   32'(e_data));
            check("m_rd_parity", 32'(rd_parity), 32'(e_par));
            check("m_rd_err",    32'(rd_err),    32'(e_err));
            check("m_count",     32'(count),     32'(m_cnt));
            check("m_full",      32'(full),      32'(m_cnt == DEPTH && m_sweep == 0));
            check("m_busy",      32'(busy),      32'(m_sweep > 0));
            check("m_wr_ready",  32'(wr_ready),  32'(m_sweep == 0 && m_cnt < DEPTH && !clear));
         end
         if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_cnt = 0; m_sweep = 0; m_sidx = 0;
            e_data = '0; e_par = 1'b0; e_err = 1'b0;
         end else begin
            e_data = m_mem[rd_index][DW:1];
            e_par  = m_mem[rd_index][0];
            e_err  = odd_ones(e_data) != e_par;
            if (m_sweep > 0) begin
               m_mem[m_sidx] = '0;
               m_sidx++;
               m_sweep--;
               if (m_sweep == 0) m_cnt = 0;
            end else if (clear) begin
               m_sweep = DEPTH;
               m_sidx  = 0;
            end else if (wr_valid && m_cnt < DEPTH) begin
               m_mem[m_cnt] = {wr_data, odd_ones(wr_data) ^ wr_inv_par};
               m_cnt++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [DW-1:0] d, input logic inv);
      wr_valid = 1'b1; wr_data = d; wr_inv_par = inv;
      tick();
      wr_valid = 1'b0; wr_inv_par = 1'b0;
   endtask

   task automatic rd_chk(input int idx, input logic [DW-1:0] d, input logic p, input logic e);
      rd_index = AW'(idx);
      tick();
      check("rd_data", 32'(rd_data), 32'(d));
      check("rd_parity", 32'(rd_parity), 32'(p));
      check("rd_err", 32'(rd_err), 32'(e));
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Counts busy cycles after the clear edge, bounded
   task automatic wait_sweep(output int n);
      n = 0;
      while (busy && n < 40) begin
         check("sweep_wr_ready", 32'(wr_ready), 32'(0));
         n++;
         tick();
      end
      check("sweep_done", 32'(busy), 32'(0));
   endtask

   initial begin
      int n;
      tick();
      tick();
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_count", 32'(count), 32'(0));
      check("rst_full", 32'(full), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_wr_ready", 32'(wr_ready), 32'(1));

      // Basic writes and parity
      wr(8'h22, 1'b0);
      wr(8'h23, 1'b0);
      rd_chk(0, 8'h22, 1'b0, 1'b0);
      rd_chk(1, 8'h23, 1'b1, 1'b0);
      check("count2", 32'(count), 32'(2));

      // Clear from count 5
      wr(8'h10, 1'b0); wr(8'h20, 1'b0); wr(8'h30, 1'b0);
      check("count5", 32'(count), 32'(5));
      pulse_clear();
      wait_sweep(n);
      check("sweep_len", 32'(n), 32'(8));
      check("clr_count", 32'(count), 32'(0));
      check("clr_wr_ready", 32'(wr_ready), 32'(1));
      for (int i = 0; i < DEPTH; i++) rd_chk(i, 8'h00, 1'b0, 1'b0);

      // Fill to FULL, then a rejected write
      for (int i = 1; i <= DEPTH; i++) wr(8'(i), 1'b0);
      check("full_flag", 32'(full), 32'(1));
      check("full_wr_ready", 32'(wr_ready), 32'(0));
      check("full_count", 32'(count), 32'(8));
      wr(8'hFF, 1'b0);
      check("full_count_after", 32'(count), 32'(8));
      rd_chk(0, 8'h01, 1'b1, 1'b0);
      rd_chk(7, 8'h08, 1'b1, 1'b0);

      // Clear from FULL, then an injected parity error
      pulse_clear();
      wait_sweep(n);
      check("sweep_len_full", 32'(n), 32'(8));
      wr(8'h22, 1'b1);
      rd_chk(0, 8'h22, 1'b1, 1'b1);

      // clear wins over a simultaneous write
      clear = 1'b1; wr_valid = 1'b1; wr_data = 8'hAA;
      tick();
      clear = 1'b0; wr_valid = 1'b0;
      check("cw_busy", 32'(busy), 32'(1));
      check("cw_count", 32'(count), 32'(1));
      wait_sweep(n);
      rd_chk(0, 8'h00, 1'b0, 1'b0);

      // Read-before-write on the same index
      rd_index = '0;
      wr(8'h5A, 1'b0);
      check("rbw_old", 32'(rd_data), 32'(8'h00));
      rd_chk(0, 8'h5A, 1'b0, 1'b0);

      // Reset aborts a sweep in its third cycle
      wr(8'h11, 1'b0); wr(8'h33, 1'b0);
      pulse_clear();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'(0));
      check("abort_count", 32'(count), 32'(0));
      check("abort_wr_ready", 32'(wr_ready), 32'(1));
      for (int i = 0; i < DEPTH; i++) rd_chk(i, 8'h00, 1'b0, 1'b0);

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "timeout");
   end

endmodule
